// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: source push strobes, UART start/busy handshake and FIFO status flags
interface uart_tx_arbiter_if;
  logic       src0_valid;
  logic [7:0] src0_data;
  logic       src1_valid;
  logic [7:0] src1_data;
  logic       tx_busy;
  logic       ovf_clr;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       src0_full;
  logic       src1_full;
  logic       src0_ovf;
  logic       src1_ovf;
  modport slave (
    input  src0_valid, src0_data, src1_valid, src1_data, tx_busy, ovf_clr,
    output tx_start, tx_data, src0_full, src1_full, src0_ovf, src1_ovf
  );
  modport master (
    output src0_valid, src0_data, src1_valid, src1_data, tx_busy, ovf_clr,
    input  tx_start, tx_data, src0_full, src1_full, src0_ovf, src1_ovf
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART TX between two FIFO-buffered byte sources.
// Define UART_TX_ARBITER_CRLF_EN to append 0x0A after every source-1 0x0D.
module uart_tx_arbiter #(
  parameter int DEPTH        = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input logic             clk,
  input logic             reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_IDLE} state_t;
  state_t          r_state, w_next;
  logic [7:0]      r_data;
  logic            r_last;
  logic [TW-1:0]   r_tmo;
  logic [1:0]      w_valid, w_push, w_pop, w_drop, w_ne, w_full, w_ovf;
  logic [1:0][7:0] w_din, w_head;
  logic            w_grant, w_load, w_ins;
  assign w_valid = {bus.src1_valid, bus.src0_valid};
  assign w_din   = {bus.src1_data, bus.src0_data};
  assign w_grant = (&w_ne) ? ~r_last : w_ne[1];
  assign w_load  = (r_state == IDLE) & (|w_ne) & ~w_ins;
  assign w_pop   = w_load ? (w_grant ? 2'b10 : 2'b01) : 2'b00;
  for (genvar s = 0; s < 2; s++) begin : g_fifo
    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_rptr, r_wptr;
    logic [CW-1:0] r_cnt, w_cnt;
    logic          r_full, r_ovf;
    // a full FIFO still accepts a push in the cycle it is popped
    assign w_push[s] = w_valid[s] & (~r_full | w_pop[s]);
    assign w_drop[s] = w_valid[s] & r_full & ~w_pop[s];
    assign w_cnt     = r_cnt + CW'(w_push[s]) - CW'(w_pop[s]);
    assign w_ne[s]   = r_cnt != '0;
    assign w_head[s] = r_mem[r_rptr];
    assign w_full[s] = r_full;
    assign w_ovf[s]  = r_ovf;
    always_ff @(posedge clk)
      if (w_push[s]) r_mem[r_wptr] <= w_din[s];
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        r_rptr <= '0;
        r_wptr <= '0;
        r_cnt  <= '0;
        r_full <= 1'b0;
        r_ovf  <= 1'b0;
      end else begin
        r_rptr <= r_rptr + AW'(w_pop[s]);
        r_wptr <= r_wptr + AW'(w_push[s]);
        r_cnt  <= w_cnt;
        r_full <= w_cnt == CW'(DEPTH);
        r_ovf  <= w_drop[s] | (r_ovf & ~bus.ovf_clr);
      end
  end
`ifdef UART_TX_ARBITER_CRLF_EN
  logic r_crlf;
  // the inserted LF takes the IDLE slot instead of arbitration and never touches last_grant
  assign w_ins = (r_state == IDLE) & r_crlf;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_crlf <= 1'b0;
    else if (w_ins) r_crlf <= 1'b0;
    else if (w_load & w_grant & (w_head[1] == 8'h0D)) r_crlf <= 1'b1;
`else
  assign w_ins = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = (w_load | w_ins) ? START : IDLE;
      START:     w_next = WAIT_BUSY;
      WAIT_BUSY: w_next = bus.tx_busy ? WAIT_IDLE : (r_tmo == TW'(BUSY_TIMEOUT - 1)) ? IDLE : WAIT_BUSY;
      WAIT_IDLE: w_next = bus.tx_busy ? WAIT_IDLE : IDLE;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state <= IDLE;
      r_data  <= 8'h00;
      r_last  <= 1'b1;
      r_tmo   <= '0;
    end else begin
      r_state <= w_next;
      r_tmo   <= (r_state == START) ? '0 : r_tmo + TW'(1);
      if (w_load) begin
        r_data <= w_head[w_grant];
        r_last <= w_grant;
      end else if (w_ins) r_data <= 8'h0A;
    end
  assign bus.tx_start  = r_state == START;
  assign bus.tx_data   = r_data;
  assign bus.src0_full = w_full[0];
  assign bus.src1_full = w_full[1];
  assign bus.src0_ovf  = w_ovf[0];
  assign bus.src1_ovf  = w_ovf[1];
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: vector table for FIFO flags, directed handshake sequences,
// and a random run scored against a queue-based model of the arbiter.
module tb_uart_tx_arbiter;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_chk = 0, n_err = 0, cyc = 0;
  int busy_mode = 0, busy_len = 1, busy_cnt = 0;
  logic start_seen = 1'b0;
  logic [7:0] txq[$];
  int txc[$];
  uart_tx_arbiter_if bus();
  uart_tx_arbiter #(.DEPTH(DEPTH), .BUSY_TIMEOUT(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    start_seen = bus.tx_start;
    if (bus.tx_start === 1'b1) begin
      txq.push_back(bus.tx_data);
      txc.push_back(cyc);
    end
  end
  // UART model: 0 = busy tied low, 1 = busy for busy_len cycles after each start, 2 = busy held high
  always @(posedge clk) begin
    #1;
    if (start_seen && busy_mode == 1) busy_cnt = busy_len;
    bus.tx_busy = (busy_mode == 2) ? 1'b1 : (busy_mode == 1) ? (busy_cnt > 0) : 1'b0;
    if (busy_cnt > 0) busy_cnt--;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic v0, input logic [7:0] d0, input logic v1, input logic [7:0] d1, input logic clr);
    bus.src0_valid = v0;
    bus.src0_data  = d0;
    bus.src1_valid = v1;
    bus.src1_data  = d1;
    bus.ovf_clr    = clr;
  endtask
  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    busy_mode = 0;
    busy_cnt = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx_start"}, bus.tx_start, 0);
    chk({tag, "_tx_data"}, bus.tx_data, 0);
    chk({tag, "_full"}, {bus.src1_full, bus.src0_full}, 0);
    chk({tag, "_ovf"}, {bus.src1_ovf, bus.src0_ovf}, 0);
  endtask
  task automatic wait_tx(input int n, input int limit);
    for (int k = 0; k < limit && txq.size() < n; k++) @(posedge clk);
  endtask
  task automatic run_random(input int n);
    logic [7:0] q0[$], q1[$];
    logic pv0, pv1, pclr, last, m_ovf0, m_ovf1, lf, d0, d1, g;
    logic [7:0] pd0, pd1, exp_b;
    do_reset();
    busy_mode = 1;
    {pv0, pv1, pclr, m_ovf0, m_ovf1, lf} = '0;
    pd0 = 8'h00;
    pd1 = 8'h00;
    last = 1'b1;
    for (int i = 0; i < n + 300; i++) begin
      @(posedge clk); #1;
      if (bus.tx_start) begin
        if (lf) begin
          chk("rnd_lf", bus.tx_data, 8'h0A);
          lf = 1'b0;
        end else if (q0.size() == 0 && q1.size() == 0) chk("rnd_spurious_start", 1, 0);
        else begin
          g = (q0.size() != 0 && q1.size() != 0) ? ~last : (q1.size() != 0);
          exp_b = g ? q1.pop_front() : q0.pop_front();
          last = g;
          chk("rnd_data", bus.tx_data, exp_b);
`ifdef UART_TX_ARBITER_CRLF_EN
          lf = g & (exp_b == 8'h0D);
`endif
        end
      end
      d0 = pv0 && q0.size() == DEPTH;
      d1 = pv1 && q1.size() == DEPTH;
      if (pv0 && !d0) q0.push_back(pd0);
      if (pv1 && !d1) q1.push_back(pd1);
      m_ovf0 = d0 | (m_ovf0 & ~pclr);
      m_ovf1 = d1 | (m_ovf1 & ~pclr);
      chk("rnd_full", {bus.src1_full, bus.src0_full}, {q1.size() == DEPTH, q0.size() == DEPTH});
      chk("rnd_ovf", {bus.src1_ovf, bus.src0_ovf}, {m_ovf1, m_ovf0});
      pv0 = (i < n) && ($urandom_range(0, 99) < 35);
      pv1 = (i < n) && ($urandom_range(0, 99) < 35);
      pd0 = 8'($urandom);
      pd1 = 8'($urandom);
      pclr = $urandom_range(0, 19) == 0;
      busy_len = $urandom_range(1, 5);
      drive(pv0, pd0, pv1, pd1, pclr);
    end
    chk("rnd_drained", q0.size() + q1.size() + int'(lf), 0);
  endtask
  typedef struct {
    logic v0; logic [7:0] d0; logic v1; logic [7:0] d1; logic clr;
    logic f0; logic f1; logic o0; logic o1;
  } vec_t;
  vec_t tv[13];
  logic [7:0] exp_seq[8];
  int k;
  initial begin
    tv[0]  = '{1'b0, 8'h00, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 8'h20, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 8'h00, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[3]  = '{1'b0, 8'h00, 1'b1, 8'h13, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[4]  = '{1'b0, 8'h00, 1'b1, 8'h14, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[5]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[6]  = '{1'b0, 8'h00, 1'b1, 8'h15, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    tv[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[8]  = '{1'b1, 8'h21, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[9]  = '{1'b1, 8'h22, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    tv[10] = '{1'b1, 8'h23, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[11] = '{1'b1, 8'h24, 1'b1, 8'h16, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tv[12] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_seq = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22, 8'h13, 8'h23};
    bus.tx_busy = 1'b0;
    do_reset();
    chk_reset_vals("rst");
    // single byte: 2-cycle latency, then spacing behind a 10-cycle busy
    busy_mode = 1;
    busy_len = 10;
    @(posedge clk); #1 drive(1'b1, 8'h41, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #1 drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    chk("lat_c1_start", bus.tx_start, 0);
    @(posedge clk); #1;
    chk("lat_c2_start", bus.tx_start, 1);
    chk("lat_c2_data", bus.tx_data, 8'h41);
    drive(1'b1, 8'h42, 1'b0, 8'h00, 1'b0);
    for (k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      if (bus.tx_start) break;
    end
    chk("spacing_cycles", k, 13);
    chk("spacing_data", bus.tx_data, 8'h42);
    // simultaneous pushes: source 0 wins first, then strict alternation
    do_reset();
    busy_mode = 1;
    busy_len = 2;
    txq.delete();
    @(posedge clk); #1 drive(1'b1, 8'h31, 1'b1, 8'h61, 1'b0);
    @(posedge clk); #1 drive(1'b1, 8'h32, 1'b1, 8'h62, 1'b0);
    @(posedge clk); #1 drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    wait_tx(4, 200);
    chk("rr_count", txq.size(), 4);
    if (txq.size() == 4) chk("rr_order", {txq[0], txq[1], txq[2], txq[3]}, 32'h3161_3262);
    // FIFO fill/overflow table with the UART held busy on an earlier byte
    do_reset();
    busy_mode = 2;
    @(posedge clk); #1 drive(1'b1, 8'hA0, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #1 drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    repeat (4) @(posedge clk);
    foreach (tv[i]) begin
      @(posedge clk); #1 drive(tv[i].v0, tv[i].d0, tv[i].v1, tv[i].d1, tv[i].clr);
      @(posedge clk); #1 drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      chk($sformatf("tbl%0d_full", i), {bus.src1_full, bus.src0_full}, {tv[i].f1, tv[i].f0});
      chk($sformatf("tbl%0d_ovf", i), {bus.src1_ovf, bus.src0_ovf}, {tv[i].o1, tv[i].o0});
    end
    txq.delete();
    busy_len = 2;
    busy_cnt = 0;
    busy_mode = 1;
    wait_tx(8, 400);
    repeat (30) @(posedge clk);
    chk("tbl_tx_count", txq.size(), 8);
    for (int i = 0; i < 8 && i < txq.size(); i++) chk($sformatf("tbl_tx%0d", i), txq[i], exp_seq[i]);
    // busy never rises: one start per byte, 16-cycle timeout back to IDLE
    do_reset();
    txq.delete();
    txc.delete();
    @(posedge clk); #1 drive(1'b1, 8'h55, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #1 drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    #1 drive(1'b1, 8'h56, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #1 drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    repeat (60) @(posedge clk);
    chk("tmo_count", txq.size(), 2);
    if (txq.size() == 2) begin
      chk("tmo_data", {txq[0], txq[1]}, 16'h5556);
      chk("tmo_gap", txc[1] - txc[0], 18);
    end
    chk("tmo_full", bus.src0_full, 0);
    // asynchronous reset in WAIT_IDLE with bytes still queued
    do_reset();
    busy_mode = 1;
    busy_len = 20;
    txq.delete();
    @(posedge clk); #1 drive(1'b1, 8'h71, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #1 drive(1'b1, 8'h72, 1'b0, 8'h00, 1'b0);
    @(posedge clk); #1 drive(1'b0, 8'h00, 1'b1, 8'h73, 1'b0);
    @(posedge clk); #1 drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1 chk_reset_vals("midrst");
    chk("midrst_started", txq.size(), 1);
    repeat (2) @(posedge clk);
    txq.delete();
    #1 reset = 1'b1;
    repeat (30) @(posedge clk);
    chk("midrst_no_tx", txq.size(), 0);
    // CR on source 1
    do_reset();
    busy_mode = 1;
    busy_len = 2;
    txq.delete();
    @(posedge clk); #1 drive(1'b0, 8'h00, 1'b1, 8'h0D, 1'b0);
    @(posedge clk); #1 drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    repeat (40) @(posedge clk);
`ifdef UART_TX_ARBITER_CRLF_EN
    chk("crlf_count", txq.size(), 2);
    if (txq.size() == 2) chk("crlf_seq", {txq[0], txq[1]}, 16'h0D0A);
`else
    chk("cr_count", txq.size(), 1);
    if (txq.size() == 1) chk("cr_seq", txq[0], 8'h0D);
`endif
    run_random(3000);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between two byte sources: the push-button data path (source 0) and the translated-keyboard data path (source 1).
- Each source has its own small FIFO, so a byte that arrives while the UART is busy is buffered, not lost.
- A round-robin scheduler pops one byte at a time and runs a start/busy handshake with the transmitter.
- Sits between the per-source producers and the UART TX block.

Parameters:
- DEPTH, 4, entries per source FIFO; power of two, minimum 2.
- BUSY_TIMEOUT, 16, cycles to wait for tx_busy to rise after tx_start before treating the byte as sent.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- src0_valid  input  1  one-cycle push strobe, source 0 (buttons).
- src0_data  input  8  byte for source 0, sampled when src0_valid=1.
- src1_valid  input  1  one-cycle push strobe, source 1 (keyboard).
- src1_data  input  8  byte for source 1, sampled when src1_valid=1.
- tx_busy  input  1  UART transmitter busy flag.
- ovf_clr  input  1  clears both sticky overflow flags.
- tx_start  output  1  one-cycle start pulse to the UART.
- tx_data  output  8  byte to transmit; held stable from tx_start until the handshake ends.
- src0_full  output  1  source 0 FIFO full.
- src1_full  output  1  source 1 FIFO full.
- src0_ovf  output  1  sticky flag: a source 0 byte was dropped.
- src1_ovf  output  1  sticky flag: a source 1 byte was dropped.

Behaviour:
- Reset (reset=0, asynchronous):
  - Both FIFOs empty.
  - tx_start=0, tx_data=0x00, srcN_full=0, srcN_ovf=0.
  - State IDLE; last_grant=1, so source 0 wins the first contention.
- Push:
  - If srcN_valid=1 and the FIFO is not full, the byte is written on that edge.
  - If the FIFO is full, the byte is dropped and srcN_ovf is set the next cycle.
  - Exception: a push into a full FIFO in the same cycle that FIFO is popped is accepted; the count is unchanged and ovf is not set.
- srcN_full is registered and reflects the count after the edge.
- Both sources may push in the same cycle; they are independent.
- Overflow flags:
  - ovf_clr=1 clears both flags.
  - If ovf_clr and a new drop happen in the same cycle, the flag is set (set wins).
- State machine, 2-bit state:
  - IDLE: if any FIFO is non-empty, pick a grant.
    - If only one FIFO is non-empty, grant it.
    - If both are non-empty, grant the source that is not last_grant.
    - Pop the head into tx_data, update last_grant, go to START.
  - START: tx_start=1 for exactly this cycle; clear the timeout counter; go to WAIT_BUSY.
  - WAIT_BUSY: when tx_busy=1, go to WAIT_IDLE. If the counter reaches BUSY_TIMEOUT-1 with tx_busy still 0, go to IDLE.
  - WAIT_IDLE: when tx_busy=0, go to IDLE.
- Minimum spacing between consecutive tx_start pulses: 4 cycles (IDLE, START, WAIT_BUSY, WAIT_IDLE).
- tx_data changes only on the IDLE→START edge.
- A byte pushed into an empty FIFO while in IDLE is eligible on the following cycle; latency from valid to tx_start is 2 cycles.
- FIFO read and write pointers wrap modulo DEPTH. The count is ceil(log2(DEPTH))+1 bits wide.
- Reset mid-handshake aborts the byte in flight. The UART is not notified.

Optional Feature:
- Macro: UART_TX_ARBITER_CRLF_EN.
- Defined:
  - After the handshake for a source 1 byte equal to 0x0D completes, the FSM skips arbitration.
  - It loads tx_data=0x0A and runs one more START/WAIT_BUSY/WAIT_IDLE handshake.
  - It then returns to IDLE.
  - last_grant is unchanged by the inserted byte, and the inserted byte never enters a FIFO.
- Undefined: 0x0D is sent like any other byte; no insertion logic is built.

Test Plan:
- Reset release, then src0_valid with 0x41 -> tx_start pulses 2 cycles later with tx_data=0x41. UART model raises tx_busy for 10 cycles -> next tx_start no earlier than the cycle after tx_busy falls.
- Same-cycle pushes src0=0x31 and src1=0x61 from reset -> transmit order 0x31 then 0x61. Next simultaneous pair 0x32/0x62 -> order 0x32, 0x62.
- Hold tx_busy=1, push 6 bytes 0x10..0x15 on source 1 with DEPTH=4 -> src1_full=1 after the 4th push, src1_ovf=1 after the 5th. After release, exactly 0x10..0x13 are transmitted. A pulse on ovf_clr -> src1_ovf=0.
- tx_busy tied 0, push 0x55 -> tx_start once, FSM returns to IDLE after BUSY_TIMEOUT=16 cycles, FIFO empty, no repeat transmission.
- Assert reset during WAIT_IDLE with 2 bytes queued -> all outputs at reset values immediately, no tx_start after release.
- With UART_TX_ARBITER_CRLF_EN: push 0x0D on source 1 -> transmitted sequence is 0x0D then 0x0A. Same stimulus without the macro -> 0x0D only.
